// File: rtl/pw_checking_param.sv
// Password checker: shifts in NUM_DIGITS digits, reads the stored word from PW ROM at intID, compares, then logs in or counts a failure.
// Login follows ROM_LAT+4 edges after the final digit; no backpressure (input pulses outside ENTRY are dropped); PW_LOCK_TIMER_EN adds a timed lockout exit.
module pw_checking_param #(
   parameter int DIGIT_W      = 4,
   parameter int NUM_DIGITS   = 6,
   parameter int ID_W         = 3,
   parameter int ADDR_W       = 5,
   parameter int ROM_LAT      = 2,
   parameter int MAX_ATTEMPTS = 3,
   parameter int LOCK_CYCLES  = 50_000_000
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [DIGIT_W-1:0]              pwdigit,
   input  logic                            pwenter,
   input  logic [ID_W-1:0]                 intID,
   input  logic                            isGuest,
   input  logic                            log_out_ctrl,
   input  logic [DIGIT_W*NUM_DIGITS-1:0]   q_PW_ROM,
   output logic [ADDR_W-1:0]               addr_PW_ROM,
   output logic                            log_in_ctrl,
   output logic                            log_out,
   output logic                            isGuest_ctrl,
   output logic [ID_W-1:0]                 intID_ctrl,
   output logic                            locked,
   output logic [3:0]                      fail_cnt
);

   localparam int PW_W   = DIGIT_W * NUM_DIGITS;
   localparam int CNT_W  = (NUM_DIGITS < 2) ? 1 : $clog2(NUM_DIGITS + 1);
   localparam int WAIT_W = (ROM_LAT < 2) ? 1 : $clog2(ROM_LAT + 1);

   typedef enum logic [2:0] {
      ST_ENTRY   = 3'd0,
      ST_FETCH   = 3'd1,
      ST_WAIT    = 3'd2,
      ST_CATCH   = 3'd3,
      ST_COMPARE = 3'd4,
      ST_PASSED  = 3'd5,
      ST_LOCKED  = 3'd6
   } state_t;

   state_t             state;
   logic [CNT_W-1:0]   digit_cnt;
   logic [PW_W-1:0]    pw;
   logic [PW_W-1:0]    rom_q;
   logic [WAIT_W-1:0]  wait_cnt;

`ifdef PW_LOCK_TIMER_EN
   localparam int LOCK_W = (LOCK_CYCLES < 2) ? 1 : $clog2(LOCK_CYCLES);
   logic [LOCK_W-1:0]  lock_tmr;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= ST_ENTRY;
         digit_cnt    <= '0;
         pw           <= '0;
         rom_q        <= '0;
         wait_cnt     <= '0;
         addr_PW_ROM  <= '0;
         log_in_ctrl  <= 1'b0;
         log_out      <= 1'b0;
         isGuest_ctrl <= 1'b0;
         intID_ctrl   <= '0;
         locked       <= 1'b0;
         fail_cnt     <= 4'd0;
`ifdef PW_LOCK_TIMER_EN
         lock_tmr     <= '0;
`endif
      end else begin
         log_out <= 1'b0;
         case (state)
            ST_ENTRY: begin
               if (pwenter) begin
                  // first digit ends up in the MSBs after NUM_DIGITS shifts
                  pw <= (pw << DIGIT_W) | PW_W'(pwdigit);
                  if (digit_cnt == CNT_W'(NUM_DIGITS - 1)) begin
                     digit_cnt <= '0;
                     state     <= ST_FETCH;
                  end else begin
                     digit_cnt <= digit_cnt + 1'b1;
                  end
               end
            end

            ST_FETCH: begin
               addr_PW_ROM <= ADDR_W'(intID);
               wait_cnt    <= WAIT_W'(ROM_LAT);
               state       <= ST_WAIT;
            end

            ST_WAIT: begin
               // the terminal zero cycle keeps the address settled for ROM_LAT full cycles before CATCH
               if (wait_cnt == '0) begin
                  state <= ST_CATCH;
               end else begin
                  wait_cnt <= wait_cnt - 1'b1;
               end
            end

            ST_CATCH: begin
               rom_q <= q_PW_ROM;
               state <= ST_COMPARE;
            end

            ST_COMPARE: begin
               if (pw == rom_q) begin
                  log_in_ctrl  <= 1'b1;
                  intID_ctrl   <= intID;
                  isGuest_ctrl <= isGuest;
                  fail_cnt     <= 4'd0;
                  state        <= ST_PASSED;
               end else begin
                  if (fail_cnt < 4'(MAX_ATTEMPTS)) begin
                     fail_cnt <= fail_cnt + 4'd1;
                  end
                  if (fail_cnt + 4'd1 >= 4'(MAX_ATTEMPTS)) begin
                     locked <= 1'b1;
                     state  <= ST_LOCKED;
`ifdef PW_LOCK_TIMER_EN
                     lock_tmr <= LOCK_W'(LOCK_CYCLES - 1);
`endif
                  end else begin
                     state <= ST_ENTRY;
                  end
               end
            end

            ST_PASSED: begin
               // logout takes priority over any coincident pwenter, which is simply dropped
               if (log_out_ctrl) begin
                  log_out      <= 1'b1;
                  log_in_ctrl  <= 1'b0;
                  isGuest_ctrl <= 1'b0;
                  intID_ctrl   <= '0;
                  pw           <= '0;
                  state        <= ST_ENTRY;
               end
            end

            ST_LOCKED: begin
               log_in_ctrl <= 1'b0;
`ifdef PW_LOCK_TIMER_EN
               if (lock_tmr == '0) begin
                  locked   <= 1'b0;
                  fail_cnt <= 4'd0;
                  state    <= ST_ENTRY;
               end else begin
                  lock_tmr <= lock_tmr - 1'b1;
               end
`else
               locked <= 1'b1;
`endif
            end

            default: begin
               state        <= ST_ENTRY;
               digit_cnt    <= '0;
               pw           <= '0;
               wait_cnt     <= '0;
               addr_PW_ROM  <= '0;
               log_in_ctrl  <= 1'b0;
               isGuest_ctrl <= 1'b0;
               intID_ctrl   <= '0;
               locked       <= 1'b0;
               fail_cnt     <= 4'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pw_checking_param.sv
// Table-driven bench for pw_checking_param with a 2-cycle PW ROM model; LOCK_CYCLES is set to 10.
module tb_pw_checking_param;

   localparam int DIGIT_W = 4;
   localparam int NDIG    = 6;
   localparam int ID_W    = 3;
   localparam int ADDR_W  = 5;
   localparam int PW_W    = DIGIT_W * NDIG;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic [DIGIT_W-1:0] pwdigit = '0;
   logic               pwenter = 1'b0;
   logic [ID_W-1:0]    intID = '0;
   logic               isGuest = 1'b0;
   logic               log_out_ctrl = 1'b0;
   logic [PW_W-1:0]    q_PW_ROM;
   logic [ADDR_W-1:0]  addr_PW_ROM;
   logic               log_in_ctrl;
   logic               log_out;
   logic               isGuest_ctrl;
   logic [ID_W-1:0]    intID_ctrl;
   logic               locked;
   logic [3:0]         fail_cnt;

   int n_vec = 0;
   int n_err = 0;

   pw_checking_param #(
      .DIGIT_W(DIGIT_W), .NUM_DIGITS(NDIG), .ID_W(ID_W), .ADDR_W(ADDR_W),
      .ROM_LAT(2), .MAX_ATTEMPTS(3), .LOCK_CYCLES(10)
   ) dut (
      .clk(clk), .rst(rst), .pwdigit(pwdigit), .pwenter(pwenter), .intID(intID),
      .isGuest(isGuest), .log_out_ctrl(log_out_ctrl), .q_PW_ROM(q_PW_ROM),
      .addr_PW_ROM(addr_PW_ROM), .log_in_ctrl(log_in_ctrl), .log_out(log_out),
      .isGuest_ctrl(isGuest_ctrl), .intID_ctrl(intID_ctrl), .locked(locked),
      .fail_cnt(fail_cnt)
   );

   always #5 clk = ~clk;

   // PW ROM with two cycles of read latency
   logic [PW_W-1:0]   rom [0:31];
   logic [ADDR_W-1:0] rom_a1;
   always @(posedge clk) begin
      rom_a1   <= addr_PW_ROM;
      q_PW_ROM <= rom[rom_a1];
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [ID_W-1:0] id;
      logic            guest;
      logic [PW_W-1:0] digits;
      logic            exp_login;
      logic [3:0]      exp_fail;
   } vec_t;

   vec_t vecs [6];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // returns #1 after the edge that samples the final pwenter
   task automatic enter(input logic [PW_W-1:0] d);
      for (int i = 0; i < NDIG; i++) begin
         pwdigit = d[PW_W-1-DIGIT_W*i -: DIGIT_W];
         pwenter = 1'b1;
         tick();
         pwenter = 1'b0;
         if (i < NDIG - 1) tick();
      end
   endtask

   task automatic expect_login(input string name);
      repeat (5) tick();
      chk({name, "_early"}, 32'(log_in_ctrl), 32'd0);
      tick();
      chk(name, 32'(log_in_ctrl), 32'd1);
   endtask

   task automatic do_logout();
      log_out_ctrl = 1'b1;
      tick();
      log_out_ctrl = 1'b0;
      chk("logout_pulse", 32'(log_out), 32'd1);
      tick();
      chk("logout_end", 32'(log_out), 32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      #2;
      chk("rst_login", 32'(log_in_ctrl), 32'd0);
      chk("rst_locked", 32'(locked), 32'd0);
      chk("rst_fail", 32'(fail_cnt), 32'd0);
      chk("rst_addr", 32'(addr_PW_ROM), 32'd0);
      chk("rst_id", 32'(intID_ctrl), 32'd0);
      chk("rst_guest", 32'(isGuest_ctrl), 32'd0);
      chk("rst_logout", 32'(log_out), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      tick();
   endtask

   int cnt;

   initial begin
      for (int i = 0; i < 32; i++) rom[i] = {8'hA5, 16'(i)};
      rom[1] = 24'h998900;
      rom[2] = 24'h123456;
      rom[3] = 24'h000000;

      vecs[0] = '{3'd1, 1'b0, 24'h998900, 1'b1, 4'd0};
      vecs[1] = '{3'd2, 1'b1, 24'h123456, 1'b1, 4'd0};
      vecs[2] = '{3'd1, 1'b0, 24'h123456, 1'b0, 4'd1};
      vecs[3] = '{3'd2, 1'b0, 24'h998900, 1'b0, 4'd2};
      vecs[4] = '{3'd1, 1'b1, 24'h998900, 1'b1, 4'd0};
      vecs[5] = '{3'd3, 1'b0, 24'h000000, 1'b1, 4'd0};

      do_reset();

      // table: each record is one full entry + compare
      for (int v = 0; v < 6; v++) begin
         intID   = vecs[v].id;
         isGuest = vecs[v].guest;
         enter(vecs[v].digits);
         repeat (5) tick();
         chk("vec_early", 32'(log_in_ctrl), 32'd0);
         tick();
         chk("vec_login", 32'(log_in_ctrl), 32'(vecs[v].exp_login));
         chk("vec_fail", 32'(fail_cnt), 32'(vecs[v].exp_fail));
         chk("vec_addr", 32'(addr_PW_ROM), 32'(vecs[v].id));
         if (vecs[v].exp_login) begin
            chk("vec_id", 32'(intID_ctrl), 32'(vecs[v].id));
            chk("vec_guest", 32'(isGuest_ctrl), 32'(vecs[v].guest));
            do_logout();
            chk("vec_id_clr", 32'(intID_ctrl), 32'd0);
         end
      end

      // log_out_ctrl outside PASSED gives no pulse
      log_out_ctrl = 1'b1;
      tick();
      log_out_ctrl = 1'b0;
      chk("logout_in_entry", 32'(log_out), 32'd0);

      // login, then logout together with pwenter: logout wins, no digit captured
      intID = 3'd1; isGuest = 1'b1;
      enter(24'h998900);
      expect_login("login_a");
      pwdigit = 4'd7; pwenter = 1'b1; log_out_ctrl = 1'b1;
      tick();
      pwenter = 1'b0; log_out_ctrl = 1'b0;
      chk("co_logout", 32'(log_out), 32'd1);
      chk("co_login", 32'(log_in_ctrl), 32'd0);
      chk("co_guest", 32'(isGuest_ctrl), 32'd0);
      tick();
      chk("co_logout_end", 32'(log_out), 32'd0);
      enter(24'h998900);
      expect_login("login_after_co");

      // pwenter held during FETCH/WAIT/CATCH is ignored
      do_logout();
      enter(24'h998900);
      pwdigit = 4'd5; pwenter = 1'b1;
      repeat (5) tick();
      pwenter = 1'b0;
      chk("busy_early", 32'(log_in_ctrl), 32'd0);
      tick();
      chk("busy_login", 32'(log_in_ctrl), 32'd1);
      do_logout();

      // one failure, three digits of a new entry, then reset mid-entry
      enter(24'h111111);
      repeat (6) tick();
      chk("pre_rst_fail", 32'(fail_cnt), 32'd1);
      for (int i = 0; i < 3; i++) begin
         pwdigit = 4'd9; pwenter = 1'b1; tick(); pwenter = 1'b0; tick();
      end
      do_reset();
      enter(24'h998900);
      expect_login("login_after_rst");
      do_logout();

      // three wrong entries lock the checker
      for (int k = 1; k <= 3; k++) begin
         enter(24'h123456);
         repeat (6) tick();
         chk("lock_fail", 32'(fail_cnt), 32'(k));
         chk("lock_flag", 32'(locked), 32'(k == 3));
      end

`ifdef PW_LOCK_TIMER_EN
      cnt = 0;
      while (locked && cnt < 100) begin
         pwdigit = 4'd9; pwenter = cnt[0];
         tick();
         cnt++;
      end
      pwenter = 1'b0;
      chk("lock_cycles", 32'(cnt), 32'd10);
      chk("unlock_fail", 32'(fail_cnt), 32'd0);
      chk("unlock_login", 32'(log_in_ctrl), 32'd0);
      enter(24'h998900);
      expect_login("login_after_unlock");
      do_logout();
`else
      enter(24'h998900);
      repeat (10) tick();
      chk("locked_login", 32'(log_in_ctrl), 32'd0);
      chk("locked_fail", 32'(fail_cnt), 32'd3);
      log_out_ctrl = 1'b1;
      tick();
      log_out_ctrl = 1'b0;
      chk("locked_logout", 32'(log_out), 32'd0);
      repeat (1000) tick();
      chk("locked_hold", 32'(locked), 32'd1);
      do_reset();
      enter(24'h998900);
      expect_login("login_after_lock_rst");
      do_logout();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
